// File: rtl/decode_scoreboard.sv
// Register-pending scoreboard: per-register in-flight counters feeding the
// decode-stage RAW hazard flag. Written on decode->execute issue, cleared by writeback.

module decode_scoreboard_cnt #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf,
    output logic             unf
);
    logic full, empty;

    assign full  = &cnt;
    assign empty = (cnt == '0);
    // A paired inc/dec on the same register nets to zero and is never an error.
    assign ovf   = inc && !dec && full;
    assign unf   = dec && !inc && empty;

    always_ff @(posedge clock) begin
        if (reset || flush)
            cnt <= '0;
        else if (inc && !dec && !full)
            cnt <= cnt + 1'b1;
        else if (dec && !inc && !empty)
            cnt <= cnt - 1'b1;
    end
endmodule

module decode_scoreboard #(
    parameter int NREG  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            check_i,
    input  logic [RA_W-1:0] rs1_i,
    input  logic            rs1_use_i,
    input  logic [RA_W-1:0] rs2_i,
    input  logic            rs2_use_i,
    input  logic [RA_W-1:0] rd_i,
    input  logic            rd_wen_i,
    input  logic            issue_i,
    input  logic            wb_valid_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic            wb_wen_i,
    input  logic            flush_i,
    output logic            raw_o,
    output logic            busy_o,
    output logic            err_o
);
    localparam int NIDX = 1 << RA_W;

    // Counter view padded to every encodable index; x0 and indices >= NREG read as 0.
    logic [NIDX-1:0][CNT_W-1:0] cnt;
    logic [NIDX-1:0]            ovf, unf;
    logic                       inc, dec;
    logic                       h1, h2, hd;
    logic                       err;

    // Flush drops same-cycle updates, so they cannot raise counter errors either.
    assign inc = issue_i && rd_wen_i && !flush_i;
    assign dec = wb_valid_i && wb_wen_i && !flush_i;

    for (genvar r = 0; r < NIDX; r++) begin : g_reg
        if (r == 0 || r >= NREG) begin : g_untracked
            assign cnt[r] = '0;
            assign ovf[r] = 1'b0;
            assign unf[r] = 1'b0;
        end else begin : g_tracked
            decode_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
                .clock (clock),
                .reset (reset),
                .flush (flush_i),
                .inc   (inc && (rd_i == RA_W'(r))),
                .dec   (dec && (wb_rd_i == RA_W'(r))),
                .cnt   (cnt[r]),
                .ovf   (ovf[r]),
                .unf   (unf[r])
            );
        end
    end

    assign h1    = rs1_use_i && (cnt[rs1_i] != '0);
    assign h2    = rs2_use_i && (cnt[rs2_i] != '0);
    assign hd    = rd_wen_i && (&cnt[rd_i]);
    assign raw_o = check_i && (h1 || h2 || hd);

    assign busy_o = |cnt;

    always_ff @(posedge clock) begin
        if (reset)
            err <= 1'b0;
        else if ((|ovf) || (|unf) || (issue_i && raw_o))
            err <= 1'b1;
    end

    assign err_o = err;
endmodule

// File: tb/tb_decode_scoreboard.sv
// Directed bench for decode_scoreboard (NREG=16 so indices >= 16 exercise the untracked path).

module tb_decode_scoreboard;
    localparam int NREG  = 16;
    localparam int RA_W  = 5;
    localparam int CNT_W = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            check_i;
    logic [RA_W-1:0] rs1_i;
    logic            rs1_use_i;
    logic [RA_W-1:0] rs2_i;
    logic            rs2_use_i;
    logic [RA_W-1:0] rd_i;
    logic            rd_wen_i;
    logic            issue_i;
    logic            wb_valid_i;
    logic [RA_W-1:0] wb_rd_i;
    logic            wb_wen_i;
    logic            flush_i;
    logic            raw_o;
    logic            busy_o;
    logic            err_o;

    int checks = 0;
    int errors = 0;

    decode_scoreboard #(.NREG(NREG), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .check_i    (check_i),
        .rs1_i      (rs1_i),
        .rs1_use_i  (rs1_use_i),
        .rs2_i      (rs2_i),
        .rs2_use_i  (rs2_use_i),
        .rd_i       (rd_i),
        .rd_wen_i   (rd_wen_i),
        .issue_i    (issue_i),
        .wb_valid_i (wb_valid_i),
        .wb_rd_i    (wb_rd_i),
        .wb_wen_i   (wb_wen_i),
        .flush_i    (flush_i),
        .raw_o      (raw_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        check_i = 0; rs1_i = 0; rs1_use_i = 0; rs2_i = 0; rs2_use_i = 0;
        rd_i = 0; rd_wen_i = 0; issue_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; wb_wen_i = 0; flush_i = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cycle();
        reset = 0;
    endtask

    task automatic issue(input logic [RA_W-1:0] rd);
        idle();
        issue_i = 1; rd_i = rd; rd_wen_i = 1;
        cycle();
        idle();
    endtask

    task automatic wb(input logic [RA_W-1:0] rd);
        idle();
        wb_valid_i = 1; wb_rd_i = rd; wb_wen_i = 1;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        check_i = 1; rs1_i = 5; rs1_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL reset_raw: got %b want 0", raw_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    endtask

    task automatic test_raw();
        issue(5);
        check_i = 1; rs2_i = 5; rs2_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL raw_set: got %b want 1", raw_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL raw_busy: got %b want 1", busy_o); end
        cycle();
        // Writeback cycle: no same-cycle release.
        wb_valid_i = 1; wb_rd_i = 5; wb_wen_i = 1;
        #1;
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL raw_no_bypass: got %b want 1", raw_o); end
        cycle();
        wb_valid_i = 0; wb_wen_i = 0;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL raw_release: got %b want 0", raw_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL raw_busy_drop: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL raw_err: got %b want 0", err_o); end
    endtask

    task automatic test_x0();
        issue(0);
        check_i = 1; rs1_i = 0; rs1_use_i = 1; rd_i = 0; rd_wen_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL x0_raw: got %b want 0", raw_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_cmax();
        issue(7); issue(7); issue(7);
        check_i = 1; rd_i = 7; rd_wen_i = 1;
        #1;
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL cmax_stall: got %b want 1", raw_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL cmax_err_pre: got %b want 0", err_o); end
        issue_i = 1;
        cycle();
        issue_i = 0;
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL cmax_err: got %b want 1", err_o); end
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL cmax_hold: got %b want 1", raw_o); end
        wb(7);
        check_i = 1; rd_i = 7; rd_wen_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL cmax_after_wb1: got %b want 0", raw_o); end
        wb(7);
        check_i = 1; rs1_i = 7; rs1_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL cmax_one_left: got %b want 1", raw_o); end
        wb(7);
        check_i = 1; rs1_i = 7; rs1_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL cmax_drained: got %b want 0", raw_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cmax_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        issue(9);
        issue_i = 1; rd_i = 9; rd_wen_i = 1;
        wb_valid_i = 1; wb_rd_i = 9; wb_wen_i = 1;
        cycle();
        idle();
        check_i = 1; rs1_i = 9; rs1_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL same_reg_persist: got %b want 1", raw_o); end
        wb(9);
        check_i = 1; rs1_i = 9; rs1_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL same_reg_count1: got %b want 0", raw_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL same_reg_err: got %b want 0", err_o); end
        issue(4);
        issue_i = 1; rd_i = 3; rd_wen_i = 1;
        wb_valid_i = 1; wb_rd_i = 4; wb_wen_i = 1;
        cycle();
        idle();
        check_i = 1; rs1_i = 3; rs1_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL diff_reg_inc: got %b want 1", raw_o); end
        rs1_use_i = 0; rs2_i = 4; rs2_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL diff_reg_dec: got %b want 0", raw_o); end
        wb(3);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL diff_reg_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL diff_reg_err: got %b want 0", err_o); end
    endtask

    task automatic test_flush();
        do_reset();
        issue(1); issue(6); issue(6);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flush_pre_busy: got %b want 1", busy_o); end
        flush_i = 1; issue_i = 1; rd_i = 2; rd_wen_i = 1;
        cycle();
        idle();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy_o); end
        check_i = 1; rs1_i = 2; rs1_use_i = 1; rs2_i = 6; rs2_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL flush_raw: got %b want 0", raw_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL flush_err_pre: got %b want 0", err_o); end
        wb(2);
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL flush_underflow: got %b want 1", err_o); end
    endtask

    task automatic test_untracked();
        do_reset();
        issue(20);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL untracked_busy: got %b want 0", busy_o); end
        check_i = 1; rs1_i = 20; rs1_use_i = 1;
        #1;
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL untracked_raw: got %b want 0", raw_o); end
        wb(20);
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL untracked_err: got %b want 0", err_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // First instruction issues; its dependent follows immediately.
        check_i = 1; issue_i = 1; rd_i = 8; rd_wen_i = 1;
        cycle();
        idle();
        check_i = 1; rs1_i = 8; rs1_use_i = 1; rd_i = 10; rd_wen_i = 1;
        #1;
        checks++; if (raw_o !== 1'b1) begin errors++; $display("FAIL b2b_stall: got %b want 1", raw_o); end
        issue_i = 1;
        cycle();
        issue_i = 0;
        #1;
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL b2b_issue_on_raw: got %b want 1", err_o); end
        reset = 1;
        cycle();
        reset = 0;
        #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL midreset_err: got %b want 0", err_o); end
        checks++; if (raw_o !== 1'b0) begin errors++; $display("FAIL midreset_raw: got %b want 0", raw_o); end
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_raw();
        test_x0();
        test_cmax();
        test_same_cycle();
        test_flush();
        test_untracked();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_scoreboard.md
# decode_scoreboard

Register-pending scoreboard that generates the read-after-write hazard flag consumed by the decode-stage controller. It tracks every destination register issued from decode to execute and not yet written back. It compares the decoding instruction's source registers against that set and holds off issue until the sources are clean. It sits beside the decode stage, is written on the decode→execute handshake, and is cleared by writeback.

## Interface
Parameters:
- NREG, 32: number of architectural registers (16 for RV32E builds).
- RA_W, 5: register-index width; must satisfy 2^RA_W ≥ NREG.
- CNT_W, 2: per-register in-flight counter width; CMAX = 2^CNT_W − 1.

Ports:
- clock  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- check_i  in  1  decode holds a valid instruction, i.e. its state is wait_ready.
- rs1_i  in  RA_W  source register 1 index.
- rs1_use_i  in  1  instruction reads rs1.
- rs2_i  in  RA_W  source register 2 index.
- rs2_use_i  in  1  instruction reads rs2.
- rd_i  in  RA_W  destination register index.
- rd_wen_i  in  1  instruction writes rd.
- issue_i  in  1  decode→execute handshake fired this cycle (valid_post && ready_post).
- wb_valid_i  in  1  writeback commits this cycle.
- wb_rd_i  in  RA_W  writeback destination index.
- wb_wen_i  in  1  writeback writes the register file.
- flush_i  in  1  pipeline flush; drops all pending entries.
- raw_o  out  1  hazard; decode must not issue.
- busy_o  out  1  at least one register pending.
- err_o  out  1  sticky protocol-error flag.

## Operation
- State: NREG counters cnt[r], each CNT_W bits. r = 0 is never tracked, and cnt[0] stays 0 permanently.
- raw_o is combinational from registered counters only. There is no same-cycle bypass from wb_*.
  - raw_o = check_i && (h1 || h2 || hd).
  - h1 = rs1_use_i && rs1_i≠0 && cnt[rs1_i]≠0.
  - h2 = the same test using rs2.
  - hd = rd_wen_i && rd_i≠0 && cnt[rd_i]==CMAX. This is a structural stall that prevents counter overflow.
- Increment: inc = issue_i && rd_wen_i && rd_i≠0.
- Decrement: dec = wb_valid_i && wb_wen_i && wb_rd_i≠0.
- Per-cycle update of cnt[r]:
  - +1 if only inc targets r.
  - −1 if only dec targets r.
  - Unchanged if both target the same r; the net change is zero.
  - inc and dec to different registers update both.
- Error cases (each sets err_o; err_o holds until reset):
  - inc onto a counter at CMAX: increment suppressed.
  - dec on a counter at 0: decrement suppressed.
  - issue_i while raw_o=1.
- flush_i: every counter becomes 0 next cycle. Flush has priority over any same-cycle inc and dec. err_o is unaffected.
- busy_o = OR over r of (cnt[r]≠0). It is registered-state derived, with no combinational path from inputs.
- Indices ≥ NREG are treated as untracked: no hazard, no update.

## Timing
- Reset: all cnt = 0; raw_o = 0; busy_o = 0; err_o = 0. Reset takes priority over flush and over all updates. Reset mid-operation discards all pending entries.
- Issue at edge N: a dependent instruction sees raw_o=1 in cycle N+1 (the first cycle after the edge).
- Writeback valid in cycle W: the counter decrements at the edge ending W. raw_o falls in cycle W+1 and decode may issue in W+1 at the earliest. There is no same-cycle release.
- Back-to-back instructions, where the second reads the rd of the first, always see at least one stall cycle after the first issues.
- raw_o may toggle only with check_i or the source/destination inputs within a cycle. It has no dependence on issue_i, wb_* or flush_i in the same cycle.
- One inc and one dec per cycle maximum.

## Test plan
- Reset, then check_i=1 with rs1=5, rs1_use=1 → raw_o=0, busy_o=0, err_o=0.
- Issue rd=5 at cycle 1, then check rs2=5 in cycle 2 → raw_o=1. Writeback rd=5 in cycle 4 → raw_o=0 in cycle 5; busy_o drops in cycle 5.
- Issue rd=0 with wen=1, then read x0 → raw_o stays 0 and busy_o stays 0.
- Issue rd=7 three times (CNT_W=2), then present rd_i=7, rd_wen_i=1 → raw_o=1 via the CMAX stall. Force issue_i → err_o=1 and cnt[7] stays 3. Three writebacks to 7 → cnt[7]=0.
- Same cycle: issue rd=9 and writeback rd=9 with cnt[9]=1 → cnt[9] stays 1 and raw on x9 persists. Same cycle: issue rd=3 and writeback rd=4 → cnt[3]+1, cnt[4]−1.
- Several registers pending; assert flush_i together with issue rd=2 → all counters 0 next cycle, busy_o=0, raw_o=0. Writeback on x2 afterwards → err_o=1.
